// File: rtl/spin_readout_pkg.sv
// Shared types and helpers for the ring-oscillator spin readout block.
package spin_readout_pkg;

   // Measurement sequencer states; encoding is fixed so debug tooling can decode it.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_t;

   // Mismatch counters need one extra bit so a full window (2^WINDOW_BITS) fits.
   function automatic int count_width(input int window_bits);
      return window_bits + 1;
   endfunction

endpackage

// File: rtl/spin_readout_sync.sv
// Multi-flop synchronizer for one asynchronous bit; q is the last stage.
module bit_synchronizer #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rstn,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] ff;

   // Shift the raw input through the flop chain; nothing else samples d.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ff <= '0;
      end else begin
         ff <= {ff[STAGES-2:0], d};
      end
   end

   assign q = ff[STAGES-1];

endmodule

// File: rtl/spin_readout.sv
// Spin readout: synchronizes a bank of ring oscillators, counts per-oscillator
// disagreement with oscillator 0 over a fixed window, and resolves binary spins.
//
// Handshake: start is a level request honoured only in IDLE (ignored, not
// queued, anywhere else). busy is high through SETTLE and SAMPLE. done pulses
// for the single DONE cycle, in which spins and the read registers already
// hold the new result; they keep it until the next done or reset.
module spin_readout
   import spin_readout_pkg::*;
#(
   parameter int N           = 16,
   parameter int WINDOW_BITS = 10,
   parameter int SYNC_STAGES = 2
) (
   input  logic                                 clk,
   input  logic                                 rstn,
   input  logic [N-1:0]                         osc_in,
   input  logic                                 start,
   output logic                                 busy,
   output logic                                 done,
   output logic [N-1:0]                         spins,
   input  logic [$clog2(N)-1:0]                 rd_sel,
   output logic [count_width(WINDOW_BITS)-1:0]  rd_count,
   output state_t                               dbg_state
);

   localparam int CW = count_width(WINDOW_BITS);
   localparam int SW = $clog2(SYNC_STAGES + 1);
   localparam logic [CW-1:0] HALF = CW'(1) << (WINDOW_BITS - 1);

   state_t                 state;
   logic [N-1:0]           s;
   logic [WINDOW_BITS-1:0] win_cnt;
   logic [SW-1:0]          settle_cnt;
   logic [CW-1:0]          mismatch     [N];
   logic [CW-1:0]          mismatch_nxt [N];
   logic [CW-1:0]          latched      [N];

   for (genvar g = 0; g < N; g++) begin : g_sync
      bit_synchronizer #(.STAGES(SYNC_STAGES)) u_sync (
         .clk  (clk),
         .rstn (rstn),
         .d    (osc_in[g]),
         .q    (s[g])
      );
   end

   // Counter values after this cycle's sample; oscillator 0 never disagrees with itself.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         mismatch_nxt[i] = mismatch[i];
      end
      for (int i = 1; i < N; i++) begin
         if (s[i] != s[0]) begin
            mismatch_nxt[i] = mismatch[i] + CW'(1);
         end
      end
   end

   // Measurement sequencer with registered busy/done/spins and result latches.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         spins      <= '0;
         win_cnt    <= '0;
         settle_cnt <= '0;
         for (int i = 0; i < N; i++) begin
            mismatch[i] <= '0;
            latched[i]  <= '0;
         end
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state      <= SETTLE;
                  busy       <= 1'b1;
                  win_cnt    <= '0;
                  settle_cnt <= '0;
                  for (int i = 0; i < N; i++) begin
                     mismatch[i] <= '0;
                  end
               end
            end
            SETTLE: begin
               // Flush whatever the synchronizers held before the request.
               if (settle_cnt == SW'(SYNC_STAGES)) begin
                  state <= SAMPLE;
               end else begin
                  settle_cnt <= settle_cnt + SW'(1);
               end
            end
            SAMPLE: begin
               win_cnt <= win_cnt + WINDOW_BITS'(1);
               for (int i = 0; i < N; i++) begin
                  mismatch[i] <= mismatch_nxt[i];
               end
               if (&win_cnt) begin
                  // Publish using the final sample so results are valid alongside done.
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  for (int i = 0; i < N; i++) begin
                     latched[i] <= mismatch_nxt[i];
                     spins[i]   <= (mismatch_nxt[i] > HALF);
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Debug read port; out-of-range selects read as zero.
   always_comb begin
      rd_count = '0;
      if (int'(rd_sel) < N) begin
         rd_count = latched[rd_sel];
      end
   end

   assign dbg_state = state;

endmodule

// File: tb/tb_spin_readout.sv
// Randomized self-checking bench for spin_readout (N=4 main build, N=5 build for
// out-of-range read selects). The reference model counts disagreements directly
// from the recorded input history over the window the synchronizer latency implies.
module tb_spin_readout;
   import spin_readout_pkg::*;

   localparam int WB   = 4;
   localparam int WIN  = 16;
   localparam int SYNC = 2;
   localparam int HALF = 8;
   localparam int HLEN = 8192;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   logic       start = 1'b0;
   logic [4:0] osc = '0;
   logic [2:0] rd_sel = '0;

   logic       busy4, done4, busy5, done5;
   logic [3:0] spins4;
   logic [4:0] spins5;
   logic [4:0] cnt4, cnt5;
   state_t     st4, st5;

   spin_readout #(.N(4), .WINDOW_BITS(WB), .SYNC_STAGES(SYNC)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .osc_in    (osc[3:0]),
      .start     (start),
      .busy      (busy4),
      .done      (done4),
      .spins     (spins4),
      .rd_sel    (rd_sel[1:0]),
      .rd_count  (cnt4),
      .dbg_state (st4)
   );

   spin_readout #(.N(5), .WINDOW_BITS(WB), .SYNC_STAGES(SYNC)) dut5 (
      .clk       (clk),
      .rstn      (rstn),
      .osc_in    (osc),
      .start     (start),
      .busy      (busy5),
      .done      (done5),
      .spins     (spins5),
      .rd_sel    (rd_sel),
      .rd_count  (cnt5),
      .dbg_state (st5)
   );

   // ---------------- checking ----------------
   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- oscillator drivers ----------------
   logic [3:0] pat [5];
   bit         rand_mode = 1'b0;
   int         phase = 0;

   always @(negedge clk) begin
      phase = (phase + 1) % 4;
      for (int i = 0; i < 5; i++) begin
         osc[i] = rand_mode ? 1'($urandom) : pat[i][phase];
      end
   end

   // ---------------- reference model ----------------
   int         cyc = 0;
   bit         m_valid = 1'b0;
   int         m_acc = 0;
   int         m_free = 0;
   logic [4:0] hist [HLEN];
   int         exp_cnt [5];
   logic [4:0] exp_spins = '0;

   always @(posedge clk) begin
      cyc = cyc + 1;
      hist[cyc % HLEN] = osc;
      if (!rstn) begin
         m_valid   = 1'b0;
         m_free    = 0;
         exp_spins = '0;
         for (int i = 0; i < 5; i++) exp_cnt[i] = 0;
      end else begin
         if (m_valid && cyc == m_acc + SYNC + WIN + 1) begin
            // Samples seen in SAMPLE are the inputs captured SYNC edges earlier.
            for (int i = 0; i < 5; i++) begin
               int n;
               n = 0;
               for (int k = m_acc + 2; k < m_acc + 2 + WIN; k++) begin
                  if (hist[k % HLEN][i] != hist[k % HLEN][0]) n++;
               end
               exp_cnt[i]   = n;
               exp_spins[i] = (n > HALF);
            end
         end
         if (start && cyc >= m_free) begin
            m_valid = 1'b1;
            m_acc   = cyc;
            m_free  = cyc + SYNC + WIN + 3;
         end
      end
   end

   // ---------------- per-cycle scoreboard ----------------
   int n_done = 0;

   always @(negedge clk) begin
      logic   ex_busy, ex_done;
      state_t ex_st;
      int     ex_c4, ex_c5;
      ex_busy = rstn && m_valid && cyc >= m_acc && cyc <= m_acc + SYNC + WIN;
      ex_done = rstn && m_valid && cyc == m_acc + SYNC + WIN + 1;
      ex_st   = IDLE;
      if (ex_done) ex_st = DONE;
      else if (ex_busy && cyc <= m_acc + SYNC) ex_st = SETTLE;
      else if (ex_busy) ex_st = SAMPLE;
      ex_c4 = rstn ? exp_cnt[rd_sel[1:0]] : 0;
      ex_c5 = (rstn && rd_sel < 3'd5) ? exp_cnt[rd_sel] : 0;
      chk("busy", 32'(busy4), 32'(ex_busy));
      chk("done", 32'(done4), 32'(ex_done));
      chk("state", 32'(st4), 32'(ex_st));
      chk("spins", 32'(spins4), rstn ? 32'(exp_spins[3:0]) : 32'd0);
      chk("rd_count", 32'(cnt4), 32'(ex_c4));
      chk("busy5", 32'(busy5), 32'(ex_busy));
      chk("spins5", 32'(spins5), rstn ? 32'(exp_spins) : 32'd0);
      chk("rd_count5", 32'(cnt5), 32'(ex_c5));
      if (done4) n_done++;
   end

   // ---------------- driver tasks ----------------
   task automatic wait_done(output int at_cyc);
      int k;
      k = 0;
      @(negedge clk);
      while (!done4 && k < 100) begin
         @(negedge clk);
         k++;
      end
      if (!done4) chk("done_timeout", 32'd0, 32'd1);
      at_cyc = cyc;
   endtask

   task automatic measure(output int lat);
      int c0, cd;
      @(negedge clk);
      start = 1'b1;
      c0 = cyc;
      @(negedge clk);
      start = 1'b0;
      wait_done(cd);
      lat = cd - c0;
   endtask

   task automatic check_sel(input int sel, input int exp);
      @(posedge clk);
      #1 rd_sel = 3'(sel);
      @(negedge clk);
      if (sel < 4) chk($sformatf("cnt4_sel%0d", sel), 32'(cnt4), 32'(exp));
      chk($sformatf("cnt5_sel%0d", sel), 32'(cnt5), 32'(exp));
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int lat, d1, d2, d3, nd;
      for (int i = 0; i < 5; i++) pat[i] = 4'b1100;
      repeat (3) @(negedge clk);
      chk("reset_busy", 32'(busy4), 32'd0);
      chk("reset_spins", 32'(spins4), 32'd0);
      #2 rstn = 1'b1;

      // All oscillators in phase.
      measure(lat);
      chk("lat_inphase", 32'(lat), 32'd20);
      chk("spins_inphase", 32'(spins4), 32'd0);
      for (int s = 0; s < 4; s++) check_sel(s, 0);

      // Oscillator 2 anti-phase; oscillator 4 (N=5 build only) anti-phase too.
      pat[2] = 4'b0011;
      pat[4] = 4'b0011;
      measure(lat);
      chk("spins_anti", 32'(spins4), 32'b0100);
      chk("spins5_anti", 32'(spins5), 32'b10100);
      check_sel(2, 16);
      check_sel(1, 0);
      check_sel(4, 16);
      for (int s = 5; s < 8; s++) check_sel(s, 0);

      // Quarter shift: exact tie resolves to 0; three-quarter disagreement resolves to 1.
      pat[2] = 4'b1100;
      pat[4] = 4'b1100;
      pat[1] = 4'b0110;
      measure(lat);
      chk("spin_tie", 32'(spins4[1]), 32'd0);
      check_sel(1, 8);
      pat[1] = 4'b0111;
      measure(lat);
      chk("spin_12", 32'(spins4[1]), 32'd1);
      check_sel(1, 12);

      // Second start during SAMPLE is ignored.
      nd = n_done;
      @(negedge clk);
      start = 1'b1;
      d1 = cyc;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(d2);
      chk("lat_ignored_start", 32'(d2 - d1), 32'd20);
      repeat (30) @(negedge clk);
      chk("single_done", 32'(n_done - nd), 32'd1);

      // Start held high: back-to-back measurements.
      @(negedge clk);
      start = 1'b1;
      wait_done(d1);
      wait_done(d2);
      wait_done(d3);
      start = 1'b0;
      chk("b2b_period_a", 32'(d2 - d1), 32'd21);
      chk("b2b_period_b", 32'(d3 - d2), 32'd21);
      repeat (5) @(negedge clk);

      // Reset in the middle of SAMPLE after a known result.
      pat[1] = 4'b1100;
      pat[2] = 4'b0011;
      measure(lat);
      chk("spins_pre_reset", 32'(spins4), 32'b0100);
      @(negedge clk);
      start = 1'b1;
      d1 = cyc;
      @(negedge clk);
      start = 1'b0;
      while (cyc < d1 + 14) @(negedge clk);
      #2 rstn = 1'b0;
      @(negedge clk);
      chk("abort_busy", 32'(busy4), 32'd0);
      chk("abort_spins", 32'(spins4), 32'd0);
      @(negedge clk);
      #2 rstn = 1'b1;
      nd = n_done;
      repeat (30) @(negedge clk);
      chk("no_done_after_abort", 32'(n_done - nd), 32'd0);
      measure(lat);
      chk("lat_post_reset", 32'(lat), 32'd20);
      chk("spins_post_reset", 32'(spins4), 32'b0100);
      check_sel(2, 16);

      // Randomized patterns and per-cycle random inputs against the model.
      for (int r = 0; r < 8; r++) begin
         rand_mode = 1'($urandom_range(0, 1));
         for (int i = 0; i < 5; i++) pat[i] = 4'($urandom_range(0, 15));
         measure(lat);
         chk("lat_rand", 32'(lat), 32'd20);
         for (int s = 0; s < 8; s++) begin
            @(posedge clk);
            #1 rd_sel = 3'(s);
            @(negedge clk);
         end
      end
      rand_mode = 1'b0;

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/spin_readout.md
Name: spin_readout

Overview:
- Reads the state of a bank of free-running coupled ring oscillators on the system clock.
- Synchronizes each asynchronous oscillator output into the clock domain. Oscillator 0 serves as the phase reference.
- Over a fixed sample window, counts the cycles in which each oscillator disagrees with the reference.
- Resolves each oscillator to a binary spin (in-phase = 0, anti-phase = 1) and reports per-oscillator mismatch counts for debug.
- Sits between the oscillator array outputs and the host/readout logic.

Parameters:
- N, 16, number of oscillators observed; index 0 is the phase reference.
- WINDOW_BITS, 10, sample window length = 2^WINDOW_BITS clock cycles.
- SYNC_STAGES, 2, flop stages in each input synchronizer (minimum 2).

Ports:
- clk  input  1  system clock.
- rstn  input  1  asynchronous active-low reset.
- osc_in  input  N  raw oscillator outputs; asynchronous to clk.
- start  input  1  request one measurement; sampled only in IDLE.
- busy  output  1  high in SETTLE and SAMPLE.
- done  output  1  one-cycle pulse when spins/counts update.
- spins  output  N  resolved spins; bit 0 always 0.
- rd_sel  input  $clog2(N)  selects oscillator for rd_count.
- rd_count  output  WINDOW_BITS+1  latched mismatch count of oscillator rd_sel; combinational from latched registers.

Behaviour:
- Reset (rstn low, asynchronous):
  - FSM goes to IDLE; all counters and synchronizer flops clear.
  - busy=0, done=0, spins=0; all latched counts are 0.
  - Reset mid-measurement aborts without updating spins; the next start begins fresh.
- Synchronizer: each osc_in bit passes through SYNC_STAGES flops; s[i] is the final stage. No other logic touches raw osc_in.
- FSM states IDLE, SETTLE, SAMPLE, DONE:
  - IDLE: on start=1, go to SETTLE, clear the window counter and all mismatch counters. Otherwise stay.
  - SETTLE: lasts exactly SYNC_STAGES+1 cycles to flush stale synchronizer contents, then go to SAMPLE.
  - SAMPLE: lasts exactly 2^WINDOW_BITS cycles. Each cycle, for every i in 1..N-1, mismatch[i] increments if s[i] != s[0]. mismatch[0] stays 0.
  - DONE: lasts one cycle; done=1. Latch every mismatch[i] into the read registers. Set spins[i] = (mismatch[i] > 2^(WINDOW_BITS-1)). Return to IDLE.
- Latency: start accepted at cycle t → done high at cycle t + 1 + (SYNC_STAGES+1) + 2^WINDOW_BITS.
- Width and boundary rules:
  - Counters are WINDOW_BITS+1 bits wide. Maximum value is exactly 2^WINDOW_BITS, so no overflow or saturation is possible.
  - Tie (mismatch exactly half the window) resolves to spin 0.
  - All-equal window gives count 0 and spin 0. Full-mismatch window gives count 2^WINDOW_BITS and spin 1.
- Handshake rules:
  - start while busy or in DONE is ignored and not queued; start held high continuously re-triggers on each IDLE entry.
  - spins and read registers hold their values from done until the next done or reset; they are not cleared by a new start.
- rd_sel ≥ N returns rd_count=0.

Decomposition:
- Package spin_readout_pkg holds:
  - the state encoding constants (IDLE=2'd0, SETTLE=2'd1, SAMPLE=2'd2, DONE=2'd3);
  - the count-width function WINDOW_BITS+1.
- Sub-module: bit_synchronizer (parameter STAGES; clk, rstn, d, q), instantiated N times.

Test Plan (N=4, WINDOW_BITS=4, SYNC_STAGES=2):
- All osc_in driven from the same 1/4-clk square wave; pulse start → done exactly 20 cycles later, spins=4'b0000, rd_count=0 for all rd_sel.
- osc_in[2] = ~osc_in[0], others equal → spins=4'b0100, rd_count(sel=2)=16.
- osc_in[1] quarter-period shifted from osc_in[0] (50% disagreement) → mismatch 8, spins[1]=0 (tie); shift so mismatch is 12 → spins[1]=1.
- Pulse start again during SAMPLE → ignored; done occurs once and latency is unchanged. Start held high → back-to-back measurements, done every 21 cycles.
- Deassert rstn at cycle 10 of SAMPLE after a prior result of spins=4'b0100 → busy=0, spins=0 immediately; no done until a new start; post-reset measurement is correct.
- Set rd_sel=3'd5 with N=4 (rd_sel is 2 bits, so drive out of range via N=5 build, sel=7) → rd_count=0.
